pspin_host_direct_unit: RTL and testbench
=========================================

# pspin_host_direct_unit

Executes `HostDirect` PsPIN commands: consumes a `pspin_cmd_req_t` from the command unit, performs one single-beat AXI write (NIC→host) or read (host→NIC) on the 512-bit host AXI master, and returns a `pspin_cmd_resp_t` carrying the command ID and read data. It sits behind the command unit on interface `CMD_HOSTDIRECT_ID` and is the responder end of the HPU command request/response protocol.

## Interface
- `AXI_ID`, default 0: AXI ID driven on AW/AR.
- `clk_i  in  1  clock`
- `rst_i  in  1  reset, asynchronous, active-high`
- `cmd_req_valid_i  in  1  command valid`
- `cmd_req_ready_o  out  1  command accepted when valid&ready`
- `cmd_req_i  in  pspin_cmd_req_t  command; only `cmd_id`, `cmd_type`, `descr.host_direct_cmd` used`
- `cmd_resp_valid_o  out  1  response valid`
- `cmd_resp_ready_i  in  1  response consumed when valid&ready`
- `cmd_resp_o  out  pspin_cmd_resp_t  cmd_id echo plus imm_data`
- `cmd_resp_err_o  out  1  qualifies cmd_resp_o: rejected command or non-OKAY AXI response`
- `host_req_o  out  host_wide_req_t  AXI master request`
- `host_resp_i  in  host_wide_resp_t  AXI master response`

## Operation
- FSM states: `Idle`, `Write` (AW/W pending), `WaitB`, `Read` (AR pending), `WaitR`, `Resp`.
- `Idle`: `cmd_req_ready_o`=1; on handshake, latch command. Reject (go to `Resp`, err=1, imm_data=0, no AXI traffic) if `cmd_type`≠`HostDirect`, `imm_data_size`=0, `imm_data_size`>64, or `host_addr[5:0]+imm_data_size`>64. Else `nic_to_host`=1 → `Write`, 0 → `Read`.
- Address/lanes: AXI addr = `{host_addr[63:6],6'b0}`, len 0, size 6, burst INCR, cache/prot/qos/region/user 0, `w.last`=1. Offset o=`host_addr[5:0]`, n=`imm_data_size`.
- Write: W data = `imm_data` shifted up by o bytes; strobe bits [o, o+n-1] set, others 0. AW and W valid together from `Write` entry; each valid drops independently after its own handshake; go to `WaitB` when both done. `b.ready`=1 in `WaitB`; on B, err = (bresp≠OKAY), imm_data=0 → `Resp`.
- Read: `ar.valid` in `Read`; → `WaitR` on handshake. `r.ready`=1 in `WaitR`; on R, imm_data = rdata shifted down by o bytes, bytes ≥n zeroed; err = (rresp≠OKAY) → `Resp`.
- `Resp`: `cmd_resp_valid_o`=1, outputs stable until `cmd_resp_ready_i`; then → `Idle`. Every accepted command produces exactly one response, regardless of `generate_event`.
- One command in flight; no reordering.

## Timing
- Reset values: state `Idle`; `cmd_req_ready_o`=1; `cmd_resp_valid_o`=0, `cmd_resp_err_o`=0, `cmd_resp_o`=0; all AXI valids 0, `b.ready`=`r.ready`=0.
- Accept at edge T → AW/W (or AR) valid during T+1.
- AXI response at edge R → `cmd_resp_valid_o` during R+1.
- Rejected command at T → response valid during T+1.
- Minimum per-command occupancy with zero-wait AXI and ready response: write 4 cycles, read 4 cycles, reject 2 cycles.
- `cmd_req_ready_o` is 0 outside `Idle`; no combinational path from `cmd_req_valid_i` to any AXI valid or from `host_resp_i` to `cmd_resp_valid_o`.
- W may handshake before AW or vice versa; both orders, and simultaneous, are required to work.
- `rst_i` mid-transaction: all valids drop immediately; the outstanding AXI transaction is abandoned (global reset).

## Structure
- Shared package: `HOST_DIRECT_LANE_BYTES` = `AXI_WIDE_DW/8`, `HOST_DIRECT_AXSIZE` = `$clog2(AXI_WIDE_DW/8)`; reuse the existing `host_wide_*` AXI types and `pspin_cmd_*` types unchanged.
- One sub-module, `pspin_host_direct_align`: combinational byte shift-up plus strobe generation (write) and shift-down plus mask (read) for offset o and count n.

## Test plan
- Write: addr `0x1000_0010`, size 8, imm_data[63:0]=`0x1122334455667788`, nic_to_host=1 → AW addr `0x1000_0000`, strb=`0xFF<<16`, wdata bytes 16..23 = 88..11, response err=0, cmd_id echoed.
- Read: addr `0x40`, size 64, host returns rdata pattern byte i=i → imm_data byte i=i, err=0; repeat at addr `0x7C`, size 4 → imm_data=`0x3F3E3D3C`, upper bytes 0.
- Reject: size 0; size 65; addr offset 60 with size 8; cmd_type `NICSend` → response next cycle with err=1, no AXI valid ever asserted.
- AXI errors and ordering: W ready 3 cycles before AW ready, BRESP=SLVERR → single B accepted, err=1; RRESP=DECERR → err=1.
- Backpressure: `cmd_resp_ready_i` held 0 for 5 cycles → response stable, `cmd_req_ready_o`=0 throughout; back-to-back commands produce responses in order.
- Reset asserted while in `WaitB` → all valids 0 immediately, `cmd_req_ready_o`=1 after release.

Source files
------------

// File: rtl/pspin_host_direct_pkg.sv
// Shared types for the PsPIN host-direct command path: wide host AXI channels,
// HPU command request/response structs and host-direct lane constants.
package pspin_host_direct_pkg;

    localparam int AXI_WIDE_DW  = 512;
    localparam int AXI_HOST_AW  = 64;
    localparam int AXI_WIDE_IW  = 4;
    localparam int AXI_WIDE_UW  = 1;

    localparam int HOST_DIRECT_LANE_BYTES = AXI_WIDE_DW / 8;
    localparam int HOST_DIRECT_AXSIZE     = $clog2(AXI_WIDE_DW / 8);

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef logic [AXI_WIDE_IW-1:0] host_wide_id_t;

    typedef struct packed {
        host_wide_id_t          id;
        logic [AXI_HOST_AW-1:0] addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
        logic                   lock;
        logic [3:0]             cache;
        logic [2:0]             prot;
        logic [3:0]             qos;
        logic [3:0]             region;
        logic [5:0]             atop;
        logic [AXI_WIDE_UW-1:0] user;
    } host_wide_aw_chan_t;

    typedef struct packed {
        logic [AXI_WIDE_DW-1:0]   data;
        logic [AXI_WIDE_DW/8-1:0] strb;
        logic                     last;
        logic [AXI_WIDE_UW-1:0]   user;
    } host_wide_w_chan_t;

    typedef struct packed {
        host_wide_id_t          id;
        logic [1:0]             resp;
        logic [AXI_WIDE_UW-1:0] user;
    } host_wide_b_chan_t;

    typedef struct packed {
        host_wide_id_t          id;
        logic [AXI_HOST_AW-1:0] addr;
        logic [7:0]             len;
        logic [2:0]             size;
        logic [1:0]             burst;
        logic                   lock;
        logic [3:0]             cache;
        logic [2:0]             prot;
        logic [3:0]             qos;
        logic [3:0]             region;
        logic [AXI_WIDE_UW-1:0] user;
    } host_wide_ar_chan_t;

    typedef struct packed {
        host_wide_id_t          id;
        logic [AXI_WIDE_DW-1:0] data;
        logic [1:0]             resp;
        logic                   last;
        logic [AXI_WIDE_UW-1:0] user;
    } host_wide_r_chan_t;

    typedef struct packed {
        host_wide_aw_chan_t aw;
        logic               aw_valid;
        host_wide_w_chan_t  w;
        logic               w_valid;
        logic               b_ready;
        host_wide_ar_chan_t ar;
        logic               ar_valid;
        logic               r_ready;
    } host_wide_req_t;

    typedef struct packed {
        logic              aw_ready;
        logic              ar_ready;
        logic              w_ready;
        logic              b_valid;
        host_wide_b_chan_t b;
        logic              r_valid;
        host_wide_r_chan_t r;
    } host_wide_resp_t;

    typedef enum logic [1:0] {
        HostMemCpy = 2'd0,
        NICSend    = 2'd1,
        HostDirect = 2'd2
    } pspin_cmd_type_t;

    typedef logic [7:0] pspin_cmd_id_t;

    typedef struct packed {
        logic                   nic_to_host;
        logic [AXI_HOST_AW-1:0] host_addr;
        logic [7:0]             imm_data_size;
        logic [AXI_WIDE_DW-1:0] imm_data;
    } pspin_host_direct_cmd_t;

    typedef struct packed {
        pspin_host_direct_cmd_t host_direct_cmd;
    } pspin_cmd_descr_t;

    typedef struct packed {
        pspin_cmd_id_t    cmd_id;
        logic             generate_event;
        pspin_cmd_type_t  cmd_type;
        pspin_cmd_descr_t descr;
    } pspin_cmd_req_t;

    typedef struct packed {
        pspin_cmd_id_t          cmd_id;
        logic [AXI_WIDE_DW-1:0] imm_data;
    } pspin_cmd_resp_t;

    // A command is only executable if it fits entirely inside one 64-byte host beat.
    function automatic logic host_direct_reject(input pspin_cmd_req_t req);
        logic [8:0] end_byte;
        end_byte = {3'b0, req.descr.host_direct_cmd.host_addr[5:0]}
                 + {1'b0, req.descr.host_direct_cmd.imm_data_size};
        return (req.cmd_type != HostDirect)
            || (req.descr.host_direct_cmd.imm_data_size == 8'd0)
            || (req.descr.host_direct_cmd.imm_data_size > 8'd64)
            || (end_byte > 9'd64);
    endfunction

endpackage

// File: rtl/pspin_host_direct_align.sv
// Byte-lane alignment between the command immediate and one 512-bit host beat:
// shift-up plus strobe for writes, shift-down plus byte mask for reads.
module pspin_host_direct_align
    import pspin_host_direct_pkg::*;
(
    input  logic [5:0]                        offset_i,
    input  logic [7:0]                        count_i,
    input  logic [AXI_WIDE_DW-1:0]            wr_data_i,
    output logic [AXI_WIDE_DW-1:0]            wr_data_o,
    output logic [HOST_DIRECT_LANE_BYTES-1:0] wr_strb_o,
    input  logic [AXI_WIDE_DW-1:0]            rd_data_i,
    output logic [AXI_WIDE_DW-1:0]            rd_data_o
);

    logic [8:0]             end_byte;
    logic [AXI_WIDE_DW-1:0] rd_shifted;

    always_comb begin
        end_byte   = {3'b0, offset_i} + {1'b0, count_i};
        wr_data_o  = wr_data_i << {offset_i, 3'b000};
        rd_shifted = rd_data_i >> {offset_i, 3'b000};
        for (int i = 0; i < HOST_DIRECT_LANE_BYTES; i++) begin
            wr_strb_o[i]        = (9'(i) >= {3'b0, offset_i}) && (9'(i) < end_byte);
            rd_data_o[i*8 +: 8] = (9'(i) < {1'b0, count_i}) ? rd_shifted[i*8 +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/pspin_host_direct_unit.sv
// HostDirect command executor: one single-beat AXI write or read per command
// on the wide host master, answered with one command response.
module pspin_host_direct_unit
    import pspin_host_direct_pkg::*;
#(
    parameter host_wide_id_t AXI_ID = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_req_valid_i,
    output logic            cmd_req_ready_o,
    input  pspin_cmd_req_t  cmd_req_i,
    output logic            cmd_resp_valid_o,
    input  logic            cmd_resp_ready_i,
    output pspin_cmd_resp_t cmd_resp_o,
    output logic            cmd_resp_err_o,
    output host_wide_req_t  host_req_o,
    input  host_wide_resp_t host_resp_i
);

    typedef enum logic [2:0] {Idle, Write, WaitB, Read, WaitR, Resp} state_e;

    state_e                            state_q, state_d;
    logic                              aw_done_q, aw_done_d;
    logic                              w_done_q, w_done_d;
    logic                              err_q, err_d;
    pspin_cmd_resp_t                   resp_q, resp_d;
    logic                              load_cmd;
    pspin_cmd_id_t                     cmd_id_q;
    pspin_host_direct_cmd_t            hd_q;
    logic [AXI_WIDE_DW-1:0]            wr_data, rd_data;
    logic [HOST_DIRECT_LANE_BYTES-1:0] wr_strb;
    logic                              unused_inputs;

    assign unused_inputs = ^{cmd_req_i.generate_event, host_resp_i.b.id, host_resp_i.b.user,
                             host_resp_i.r.id, host_resp_i.r.last, host_resp_i.r.user};

    pspin_host_direct_align i_align (
        .offset_i  (hd_q.host_addr[5:0]),
        .count_i   (hd_q.imm_data_size),
        .wr_data_i (hd_q.imm_data),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .rd_data_i (host_resp_i.r.data),
        .rd_data_o (rd_data)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
        state_d          = state_q;
        aw_done_d        = aw_done_q;
        w_done_d         = w_done_q;
        err_d            = err_q;
        resp_d           = resp_q;
        load_cmd         = 1'b0;
        cmd_req_ready_o  = 1'b0;
        cmd_resp_valid_o = 1'b0;

        host_req_o          = '0;
        host_req_o.aw.id    = AXI_ID;
        host_req_o.aw.addr  = {hd_q.host_addr[63:6], 6'b0};
        host_req_o.aw.size  = 3'(HOST_DIRECT_AXSIZE);
        host_req_o.aw.burst = AXI_BURST_INCR;
        host_req_o.ar.id    = AXI_ID;
        host_req_o.ar.addr  = {hd_q.host_addr[63:6], 6'b0};
        host_req_o.ar.size  = 3'(HOST_DIRECT_AXSIZE);
        host_req_o.ar.burst = AXI_BURST_INCR;
        host_req_o.w.data   = wr_data;
        host_req_o.w.strb   = wr_strb;
        host_req_o.w.last   = 1'b1;

        case (state_q)
            Idle: begin
                cmd_req_ready_o = 1'b1;
                if (cmd_req_valid_i) begin
                    load_cmd  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (host_direct_reject(cmd_req_i)) begin
                        resp_d.cmd_id   = cmd_req_i.cmd_id;
                        resp_d.imm_data = '0;
                        err_d           = 1'b1;
                        state_d         = Resp;
                    end else if (cmd_req_i.descr.host_direct_cmd.nic_to_host) begin
                        state_d = Write;
                    end else begin
                        state_d = Read;
                    end
                end
            end
            Write: begin
                // AW and W complete independently; either may finish first.
                host_req_o.aw_valid = !aw_done_q;
                host_req_o.w_valid  = !w_done_q;
                aw_done_d = aw_done_q || host_resp_i.aw_ready;
                w_done_d  = w_done_q || host_resp_i.w_ready;
                if (aw_done_d && w_done_d) state_d = WaitB;
            end
            WaitB: begin
                host_req_o.b_ready = 1'b1;
                if (host_resp_i.b_valid) begin
                    resp_d.cmd_id   = cmd_id_q;
                    resp_d.imm_data = '0;
                    err_d           = (host_resp_i.b.resp != AXI_RESP_OKAY);
                    state_d         = Resp;
                end
            end
            Read: begin
                host_req_o.ar_valid = 1'b1;
                if (host_resp_i.ar_ready) state_d = WaitR;
            end
            WaitR: begin
                host_req_o.r_ready = 1'b1;
                if (host_resp_i.r_valid) begin
                    resp_d.cmd_id   = cmd_id_q;
                    resp_d.imm_data = rd_data;
                    err_d           = (host_resp_i.r.resp != AXI_RESP_OKAY);
                    state_d         = Resp;
                end
            end
            Resp: begin
                cmd_resp_valid_o = 1'b1;
                if (cmd_resp_ready_i) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    assign cmd_resp_o     = resp_q;
    assign cmd_resp_err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q   <= Idle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            resp_q    <= resp_d;
        end
    end

    // NOTE: the latched command is pure datapath, only read after a load, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (load_cmd) begin
            cmd_id_q <= cmd_req_i.cmd_id;
            hd_q     <= cmd_req_i.descr.host_direct_cmd;
        end
    end

endmodule

// File: tb/tb_pspin_host_direct_unit.sv
// Bench for pspin_host_direct_unit: directed scenarios then randomized commands,
// each compared against a byte-level reference model of host-direct behaviour.
module tb_pspin_host_direct_unit;
    import pspin_host_direct_pkg::*;

    logic            clk;
    logic            rst;
    logic            cmd_req_valid;
    logic            cmd_req_ready;
    pspin_cmd_req_t  cmd_req;
    logic            resp_valid;
    logic            resp_ready;
    pspin_cmd_resp_t resp;
    logic            resp_err;
    host_wide_req_t  hreq;
    host_wide_resp_t hresp;

    int tests = 0;
    int fails = 0;

    pspin_host_direct_unit dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cmd_req_valid_i  (cmd_req_valid),
        .cmd_req_ready_o  (cmd_req_ready),
        .cmd_req_i        (cmd_req),
        .cmd_resp_valid_o (resp_valid),
        .cmd_resp_ready_i (resp_ready),
        .cmd_resp_o       (resp),
        .cmd_resp_err_o   (resp_err),
        .host_req_o       (hreq),
        .host_resp_i      (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte arithmetic over one 64-byte host line.
    function automatic bit m_reject(input pspin_cmd_type_t t, input logic [63:0] a, input logic [7:0] n);
        int o;
        o = int'(a % 64);
        return (t != HostDirect) || (n == 0) || (n > 64) || (o + int'(n) > 64);
    endfunction

    function automatic logic [63:0] m_strb(input logic [63:0] a, input logic [7:0] n);
        int o;
        logic [63:0] s;
        o = int'(a % 64);
        for (int b = 0; b < 64; b++) s[b] = (b >= o) && (b < o + int'(n));
        return s;
    endfunction

    function automatic logic [511:0] m_mask(input logic [63:0] s);
        logic [511:0] m;
        for (int b = 0; b < 64; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    function automatic logic [511:0] m_wdata(input logic [511:0] imm, input logic [63:0] a, input logic [7:0] n);
        int o;
        logic [511:0] r;
        o = int'(a % 64);
        r = '0;
        for (int b = 0; b < 64; b++)
            if (b >= o && b < o + int'(n)) r[b*8 +: 8] = imm[(b-o)*8 +: 8];
        return r;
    endfunction

    function automatic logic [511:0] m_rdata(input logic [511:0] hl, input logic [63:0] a, input logic [7:0] n);
        int o;
        logic [511:0] r;
        o = int'(a % 64);
        r = '0;
        for (int k = 0; k < int'(n); k++) r[k*8 +: 8] = hl[(o+k)*8 +: 8];
        return r;
    endfunction

    // Issues one command, plays the AXI slave, then checks and drains the response.
    task automatic run_cmd(input string tag, input pspin_cmd_type_t t, input logic [7:0] id,
                           input logic n2h, input logic [63:0] addr, input logic [7:0] n,
                           input logic [511:0] imm, input int aw_dly, input int w_dly,
                           input int ar_dly, input logic [1:0] axi_resp,
                           input logic [511:0] hl, input int rsp_dly);
        bit           rej;
        bit           aw_seen, w_seen, ar_seen;
        int           cyc;
        logic [511:0] exp_imm;
        logic         exp_err;

        rej = m_reject(t, addr, n);
        @(negedge clk);
        cmd_req = '0;
        cmd_req.cmd_id = id;
        cmd_req.cmd_type = t;
        cmd_req.generate_event = id[0];
        cmd_req.descr.host_direct_cmd.nic_to_host = n2h;
        cmd_req.descr.host_direct_cmd.host_addr = addr;
        cmd_req.descr.host_direct_cmd.imm_data_size = n;
        cmd_req.descr.host_direct_cmd.imm_data = imm;
        cmd_req_valid = 1'b1;
        check({tag, ".req_ready"}, cmd_req_ready, 1'b1);
        @(negedge clk);
        cmd_req_valid = 1'b0;

        if (rej) begin
            exp_imm = '0;
            exp_err = 1'b1;
        end else if (n2h) begin
            exp_imm = '0;
            exp_err = (axi_resp != AXI_RESP_OKAY);
            check({tag, ".aw_w_valid_t1"}, {hreq.aw_valid, hreq.w_valid, hreq.ar_valid}, 3'b110);
            aw_seen = 0;
            w_seen  = 0;
            cyc     = 0;
            while (!(aw_seen && w_seen) && cyc < 64) begin
                hresp.aw_ready = (cyc >= aw_dly);
                hresp.w_ready  = (cyc >= w_dly);
                if (aw_seen) check({tag, ".aw_dropped"}, hreq.aw_valid, 1'b0);
                if (w_seen)  check({tag, ".w_dropped"}, hreq.w_valid, 1'b0);
                if (hreq.aw_valid && hresp.aw_ready) begin
                    check({tag, ".aw_addr"}, hreq.aw.addr, addr - (addr % 64));
                    check({tag, ".aw_fmt"}, {hreq.aw.id, hreq.aw.len, hreq.aw.size, hreq.aw.burst},
                          {4'd0, 8'd0, 3'd6, 2'b01});
                    aw_seen = 1;
                end
                if (hreq.w_valid && hresp.w_ready) begin
                    check({tag, ".w_strb"}, hreq.w.strb, m_strb(addr, n));
                    check({tag, ".w_data"}, hreq.w.data & m_mask(m_strb(addr, n)), m_wdata(imm, addr, n));
                    check({tag, ".w_last"}, hreq.w.last, 1'b1);
                    w_seen = 1;
                end
                @(negedge clk);
                cyc++;
            end
            hresp.aw_ready = 1'b0;
            hresp.w_ready  = 1'b0;
            check({tag, ".aw_w_done"}, {aw_seen, w_seen}, 2'b11);
            check({tag, ".b_ready"}, {hreq.b_ready, hreq.aw_valid, hreq.w_valid}, 3'b100);
            hresp.b_valid = 1'b1;
            hresp.b.resp  = axi_resp;
            @(negedge clk);
            hresp.b_valid = 1'b0;
            check({tag, ".b_single"}, hreq.b_ready, 1'b0);
        end else begin
            exp_imm = m_rdata(hl, addr, n);
            exp_err = (axi_resp != AXI_RESP_OKAY);
            check({tag, ".ar_valid_t1"}, {hreq.aw_valid, hreq.w_valid, hreq.ar_valid}, 3'b001);
            ar_seen = 0;
            cyc     = 0;
            while (!ar_seen && cyc < 64) begin
                hresp.ar_ready = (cyc >= ar_dly);
                if (hreq.ar_valid && hresp.ar_ready) begin
                    check({tag, ".ar_addr"}, hreq.ar.addr, addr - (addr % 64));
                    check({tag, ".ar_fmt"}, {hreq.ar.len, hreq.ar.size, hreq.ar.burst}, {8'd0, 3'd6, 2'b01});
                    ar_seen = 1;
                end
                @(negedge clk);
                cyc++;
            end
            hresp.ar_ready = 1'b0;
            check({tag, ".ar_done"}, ar_seen, 1'b1);
            check({tag, ".r_ready"}, {hreq.r_ready, hreq.ar_valid}, 2'b10);
            hresp.r_valid = 1'b1;
            hresp.r.data  = hl;
            hresp.r.resp  = axi_resp;
            hresp.r.last  = 1'b1;
            @(negedge clk);
            hresp.r_valid = 1'b0;
            hresp.r.data  = '0;
            check({tag, ".r_single"}, hreq.r_ready, 1'b0);
        end

        for (int k = 0; k <= rsp_dly; k++) begin
            check({tag, ".resp_valid"}, resp_valid, 1'b1);
            check({tag, ".resp_id"}, resp.cmd_id, id);
            check({tag, ".resp_err"}, resp_err, exp_err);
            check({tag, ".resp_imm"}, resp.imm_data, exp_imm);
            check({tag, ".busy"}, {cmd_req_ready, hreq.aw_valid, hreq.w_valid, hreq.ar_valid}, 4'b0000);
            if (k == rsp_dly) resp_ready = 1'b1;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        check({tag, ".idle_after"}, {resp_valid, cmd_req_ready}, 2'b01);
    endtask

    logic [511:0]    pat;
    logic [511:0]    rimm;
    logic [511:0]    rline;
    logic [63:0]     raddr;
    logic [7:0]      rn;
    logic [1:0]      rresp;
    pspin_cmd_type_t rtype;
    logic [1:0]      resp_codes [4];

    initial begin
        rst = 1'b1;
        cmd_req_valid = 1'b0;
        cmd_req = '0;
        resp_ready = 1'b0;
        hresp = '0;
        for (int i = 0; i < 64; i++) pat[i*8 +: 8] = 8'(i);
        resp_codes[0] = AXI_RESP_OKAY;
        resp_codes[1] = AXI_RESP_OKAY;
        resp_codes[2] = AXI_RESP_SLVERR;
        resp_codes[3] = AXI_RESP_DECERR;

        @(negedge clk);
        @(negedge clk);
        check("reset.outputs", {cmd_req_ready, resp_valid, resp_err, hreq.aw_valid, hreq.w_valid,
                                hreq.ar_valid, hreq.b_ready, hreq.r_ready}, 8'b1000_0000);
        check("reset.resp", resp, '0);
        rst = 1'b0;

        run_cmd("wr_basic", HostDirect, 8'h11, 1'b1, 64'h1000_0010, 8'd8,
                {448'h0, 64'h1122_3344_5566_7788}, 0, 0, 0, AXI_RESP_OKAY, '0, 0);
        run_cmd("rd_full", HostDirect, 8'h22, 1'b0, 64'h40, 8'd64, '0, 0, 0, 0, AXI_RESP_OKAY, pat, 0);
        run_cmd("rd_tail", HostDirect, 8'h23, 1'b0, 64'h7C, 8'd4, '0, 0, 0, 0, AXI_RESP_OKAY, pat, 0);
        check("rd_tail.value", m_rdata(pat, 64'h7C, 8'd4), {480'h0, 32'h3F3E_3D3C});

        run_cmd("rej_size0", HostDirect, 8'h30, 1'b1, 64'h100, 8'd0, '1, 0, 0, 0, AXI_RESP_OKAY, '0, 0);
        run_cmd("rej_size65", HostDirect, 8'h31, 1'b0, 64'h100, 8'd65, '1, 0, 0, 0, AXI_RESP_OKAY, '0, 0);
        run_cmd("rej_cross", HostDirect, 8'h32, 1'b1, 64'h13C, 8'd8, '1, 0, 0, 0, AXI_RESP_OKAY, '0, 0);
        run_cmd("rej_type", NICSend, 8'h33, 1'b1, 64'h100, 8'd8, '1, 0, 0, 0, AXI_RESP_OKAY, '0, 0);

        run_cmd("wr_w_first", HostDirect, 8'h40, 1'b1, 64'h2000_0005, 8'd16, {16{32'hA5C3_0F96}},
                3, 0, 0, AXI_RESP_SLVERR, '0, 0);
        run_cmd("wr_aw_first", HostDirect, 8'h41, 1'b1, 64'h2000_0000, 8'd64, {16{32'h1234_5678}},
                0, 2, 0, AXI_RESP_OKAY, '0, 0);
        run_cmd("rd_decerr", HostDirect, 8'h42, 1'b0, 64'h3000_0021, 8'd10, '0, 0, 0, 2,
                AXI_RESP_DECERR, ~pat, 0);

        run_cmd("bp_write", HostDirect, 8'h50, 1'b1, 64'h88, 8'd3, {509'h0, 3'h5}, 0, 0, 0, AXI_RESP_OKAY, '0, 5);
        run_cmd("bp_read", HostDirect, 8'h51, 1'b0, 64'hC8, 8'd7, '0, 0, 0, 0, AXI_RESP_OKAY, pat, 5);
        run_cmd("bp_reject", HostDirect, 8'h52, 1'b0, 64'hC8, 8'd0, '0, 0, 0, 0, AXI_RESP_OKAY, pat, 5);

        // Reset while the write waits for its B response.
        @(negedge clk);
        cmd_req = '0;
        cmd_req.cmd_id = 8'h60;
        cmd_req.cmd_type = HostDirect;
        cmd_req.descr.host_direct_cmd.nic_to_host = 1'b1;
        cmd_req.descr.host_direct_cmd.host_addr = 64'h400;
        cmd_req.descr.host_direct_cmd.imm_data_size = 8'd4;
        cmd_req_valid = 1'b1;
        @(negedge clk);
        cmd_req_valid = 1'b0;
        hresp.aw_ready = 1'b1;
        hresp.w_ready = 1'b1;
        @(negedge clk);
        hresp.aw_ready = 1'b0;
        hresp.w_ready = 1'b0;
        check("rst_mid.in_waitb", {hreq.b_ready, cmd_req_ready}, 2'b10);
        rst = 1'b1;
        #1;
        check("rst_mid.valids", {hreq.aw_valid, hreq.w_valid, hreq.ar_valid, hreq.b_ready,
                                 hreq.r_ready, resp_valid}, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid.after", {cmd_req_ready, resp_valid, resp_err}, 3'b100);

        for (int it = 0; it < 40; it++) begin
            rtype = ($urandom_range(0, 9) == 0) ? NICSend : HostDirect;
            rn = 8'($urandom_range(0, 70));
            raddr = {$urandom, $urandom};
            if (rn >= 1 && rn <= 64 && $urandom_range(0, 4) != 0)
                raddr[5:0] = 6'($urandom_range(0, 64 - int'(rn)));
            for (int k = 0; k < 16; k++) begin
                rimm[k*32 +: 32]  = $urandom;
                rline[k*32 +: 32] = $urandom;
            end
            rresp = resp_codes[$urandom_range(0, 3)];
            run_cmd($sformatf("rand%0d", it), rtype, 8'($urandom), 1'($urandom), raddr, rn, rimm,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rresp,
                    rline, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
